regfile_sb: RTL
===============

# regfile_sb

Parametrised, scoreboarded integer register file for the pipelined RISC-V core. It replaces the fixed two-port regfile and adds:
- a configurable number of read ports;
- architectural x0 hardwired to zero;
- optional write-to-read bypass;
- a per-register busy scoreboard for hazard detection;
- a post-reset clear sweep FSM, so no reset fan-out reaches the storage array.

It sits between decode (reads, issue marking) and writeback.

## Interface
- DATA_WIDTH, 64, register width in bits
- ADDRESS_WIDTH, 5, register address width
- REGISTER_SIZE, 2**ADDRESS_WIDTH, number of architectural registers
- NUM_READ, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle writeback data is forwarded to reads
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- ra  in  NUM_READ x ADDRESS_WIDTH  read addresses
- rd  out  NUM_READ x DATA_WIDTH  read data, combinational
- rbusy  out  NUM_READ  1 = register at ra[i] has a pending write
- issue_valid  in  1  mark issue_addr busy at this edge
- issue_addr  in  ADDRESS_WIDTH  destination register of the issued instruction
- wb_valid  in  1  writeback strobe
- wb_addr  in  ADDRESS_WIDTH  writeback register
- wb_data  in  DATA_WIDTH  writeback value
- ready  out  1  1 = sweep done; issue and writeback accepted

## Operation
- **FSM states:** CLEAR and RUN.
  - reset forces CLEAR, sets sweep index = 1 and clears all busy bits in the same edge.
  - In CLEAR, each edge writes 0 to reg[index] and increments index.
  - The edge that writes index == REGISTER_SIZE-1 moves the FSM to RUN.
- **In CLEAR:**
  - ready = 0.
  - issue_valid and wb_valid are ignored.
  - All rd outputs = 0 and all rbusy outputs = 0.
- **In RUN:**
  - If wb_valid and wb_addr != 0: reg[wb_addr] <= wb_data and busy[wb_addr] <= 0.
  - If issue_valid and issue_addr != 0: busy[issue_addr] <= 1.
- **Simultaneous issue and wb to the same register:**
  - The write completes.
  - busy ends at 1, because the issuing instruction is the newer producer.
- **x0:**
  - Never stored.
  - rd = 0 and rbusy = 0 whenever ra[i] == 0.
  - Writes and issues to x0 are dropped.
- **Bypass (BYPASS = 1):** if wb_valid, wb_addr == ra[i] != 0 and the FSM is in RUN:
  - rd[i] = wb_data;
  - rbusy[i] = issue_valid && issue_addr == ra[i].
- **No bypass (BYPASS = 0):** reads return the stored value and the current busy bit.
- **Reset mid-sweep:** the sweep restarts at index 1; the full sweep length is required again.
- **Reset in RUN:** busy bits clear immediately and the FSM returns to CLEAR.

## Timing
- Read path is combinational: zero latency, from ra, the stored state and the wb/issue inputs when BYPASS = 1.
- A write is visible through storage on the cycle after its edge (same cycle when bypassed).
- A busy bit sets and clears at the edge that samples issue or wb.
- Sweep length is REGISTER_SIZE-1 edges after the last reset edge. With defaults:
  - ready rises after 31 clocks;
  - the first accepted issue/wb is at the 32nd edge after reset deasserts.
- Reset values:
  - ready = 0; all rd = 0; all rbusy = 0;
  - FSM = CLEAR; index = 1.

## Structure
- Shared package regfile_pkg holds:
  - the sweep state enum (CLEAR, RUN);
  - REG_ZERO = 0;
  - default width constants shared with decode and writeback.
- Sub-module regfile_scoreboard holds the busy-bit vector and its set/clear priority, plus its own x0 masking. Instantiated once.
- Storage, the FSM, the read muxes and the bypass logic stay in regfile_sb.

## Test plan
- **Reset sweep.** Assert reset 2 cycles, release. Required:
  - ready is low for exactly 31 edges;
  - every ra reads 0 throughout;
  - a wb to x5 during CLEAR is dropped (x5 reads 0 after ready).
- **Write and readback.** In RUN, wb x7 = 0xDEAD_BEEF_0000_0001. Required:
  - same cycle, ra[0] = 7 gives that value with BYPASS = 1;
  - next cycle it is returned from storage, on both ports.
- **x0.** wb x0 = 0xFFFF..., issue x0. Required: rd = 0 and rbusy = 0 for ra = 0 on every port.
- **Scoreboard.**
  - issue x3 → rbusy = 1 for ra = 3 from the next cycle;
  - wb x3 → rbusy returns to 0;
  - issue and wb to x3 on the same edge → rbusy stays 1 and the x3 value updates.
- **Mid-sweep reset.** Assert reset at sweep index 10. Required: the sweep restarts and ready rises 31 edges after the new release.
- **Reset in RUN.**
  - Setup: x4 = 9 with busy set.
  - Stimulus: assert reset for 1 cycle.
  - Required:
    - busy clears at the reset edge;
    - x4 reads 0 during the sweep and after ready.

Source files
------------

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the scoreboarded integer register file and the
// decode / writeback stages that talk to it.
//   sweep_state_e     : post-reset clear sweep state (CLEAR, RUN)
//   REG_ZERO          : architectural x0 address
//   DEF_*             : default widths shared across the pipeline
// -----------------------------------------------------------------------------
package regfile_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } sweep_state_e;

    localparam int REG_ZERO          = 0;
    localparam int DEF_DATA_WIDTH    = 64;
    localparam int DEF_ADDRESS_WIDTH = 5;
    localparam int DEF_NUM_READ      = 2;

endpackage

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// One busy bit per architectural register. A bit is set when an instruction
// targeting that register issues and cleared when its writeback arrives.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (clears every bit)
//   run          : 1 = updates accepted (register file sweep finished)
//   set_valid/addr : issue marking
//   clr_valid/addr : writeback clearing
//   ra           : per-port lookup addresses
//   busy         : per-port busy bit, x0 always reads 0
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int REGISTER_SIZE = 2**ADDRESS_WIDTH,
    parameter int NUM_READ      = DEF_NUM_READ
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    run,
    input  logic                                    set_valid,
    input  logic [ADDRESS_WIDTH-1:0]                set_addr,
    input  logic                                    clr_valid,
    input  logic [ADDRESS_WIDTH-1:0]                clr_addr,
    input  logic [NUM_READ-1:0][ADDRESS_WIDTH-1:0]  ra,
    output logic [NUM_READ-1:0]                     busy
);

    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ZERO = ADDRESS_WIDTH'(REG_ZERO);

    logic [REGISTER_SIZE-1:0] busy_q;
    logic [REGISTER_SIZE-1:0] busy_d;

    // Clear is applied before set so that an issue on the same edge as the
    // writeback of the same register leaves it busy: the issuing instruction
    // is the newer producer.
    always_comb begin
        busy_d = busy_q;
        if (run) begin
            if (clr_valid && clr_addr != ADDR_ZERO) begin
                busy_d[clr_addr] = 1'b0;
            end
            if (set_valid && set_addr != ADDR_ZERO) begin
                busy_d[set_addr] = 1'b1;
            end
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_READ; gi++) begin : g_lookup
            assign busy[gi] = (ra[gi] != ADDR_ZERO) && busy_q[ra[gi]];
        end
    endgenerate

endmodule

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// Parametrised integer register file with x0 hardwired to zero, optional
// writeback-to-read bypass, a busy scoreboard and a post-reset clear sweep
// (the storage array itself has no reset).
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   ra / rd / rbusy      : NUM_READ combinational read ports
//   issue_valid/addr     : mark destination register busy
//   wb_valid/addr/data   : writeback port
//   ready                : 1 once the clear sweep is done
// -----------------------------------------------------------------------------
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int REGISTER_SIZE = 2**ADDRESS_WIDTH,
    parameter int NUM_READ      = DEF_NUM_READ,
    parameter int BYPASS        = 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_READ-1:0][ADDRESS_WIDTH-1:0]  ra,
    output logic [NUM_READ-1:0][DATA_WIDTH-1:0]     rd,
    output logic [NUM_READ-1:0]                     rbusy,
    input  logic                                    issue_valid,
    input  logic [ADDRESS_WIDTH-1:0]                issue_addr,
    input  logic                                    wb_valid,
    input  logic [ADDRESS_WIDTH-1:0]                wb_addr,
    input  logic [DATA_WIDTH-1:0]                   wb_data,
    output logic                                    ready
);

    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ZERO  = ADDRESS_WIDTH'(REG_ZERO);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_FIRST = ADDRESS_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_LAST  = ADDRESS_WIDTH'(REGISTER_SIZE-1);

    sweep_state_e             state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] idx_q, idx_d;

    // Entry 0 is never written; every read of x0 is masked to zero.
    logic [DATA_WIDTH-1:0]    mem_q [0:REGISTER_SIZE-1];
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0]    mem_wdata;

    logic                     run;
    logic [NUM_READ-1:0]      sb_busy;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            idx_q   <= ADDR_FIRST;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic: one register cleared per edge, leave after the last.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == ST_CLEAR) begin
            idx_d = idx_q + ADDR_FIRST;
            if (idx_q == ADDR_LAST) begin
                state_d = ST_RUN;
            end
        end
    end

    // Output logic: ready flag and the single storage write port, shared by
    // the sweep and writeback.
    always_comb begin
        run       = (state_q == ST_RUN);
        ready     = run;
        mem_we    = 1'b0;
        mem_waddr = idx_q;
        mem_wdata = '0;
        if (!run) begin
            mem_we = 1'b1;
        end else if (wb_valid && wb_addr != ADDR_ZERO) begin
            mem_we    = 1'b1;
            mem_waddr = wb_addr;
            mem_wdata = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    regfile_scoreboard #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .REGISTER_SIZE (REGISTER_SIZE),
        .NUM_READ      (NUM_READ)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .set_valid (issue_valid),
        .set_addr  (issue_addr),
        .clr_valid (wb_valid),
        .clr_addr  (wb_addr),
        .ra        (ra),
        .busy      (sb_busy)
    );

    // Read ports. During the sweep storage may still hold stale values, so
    // everything reads as zero until RUN.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_READ; gi++) begin : g_read
            always_comb begin
                rd[gi]    = '0;
                rbusy[gi] = 1'b0;
                if (run && ra[gi] != ADDR_ZERO) begin
                    if ((BYPASS != 0) && wb_valid && wb_addr == ra[gi]) begin
                        // Writeback clears busy; only a same-edge issue keeps it.
                        rd[gi]    = wb_data;
                        rbusy[gi] = issue_valid && (issue_addr == ra[gi]);
                    end else begin
                        rd[gi]    = mem_q[ra[gi]];
                        rbusy[gi] = sb_busy[gi];
                    end
                end
            end
        end
    endgenerate

endmodule
